// File: rtl/repl_alloc_ctrl.sv
// Per-set way-allocation controller: picks a victim on a miss, sequences the
// writeback/refill handshakes and feeds access/update strobes back to the policy.
module repl_alloc_ctrl #(
    parameter int SET_ASSOC = 4
) (
    input  logic                         clk,
    input  logic                         rst,
    input  logic                         lookup_valid,
    input  logic                         lookup_hit,
    input  logic [SET_ASSOC-1:0]         hit_way,
    input  logic [SET_ASSOC-1:0]         line_valid,
    input  logic [SET_ASSOC-1:0]         line_dirty,
    input  logic [$clog2(SET_ASSOC)-1:0] repl_index,
    output logic                         ready,
    output logic [SET_ASSOC-1:0]         access,
    output logic                         update,
    output logic [$clog2(SET_ASSOC)-1:0] victim_way,
    output logic                         wb_req,
    input  logic                         wb_ack,
    output logic                         rf_req,
    input  logic                         rf_ack,
    output logic                         alloc_done
);

    localparam int IDX_W = $clog2(SET_ASSOC);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WB     = 2'd1,
        REFILL = 2'd2,
        COMMIT = 2'd3
    } state_t;

    state_t               state_q;
    state_t               state_d;
    logic [IDX_W-1:0]     victim_q;
    logic [SET_ASSOC-1:0] access_q;
    logic                 update_q;

    logic [IDX_W-1:0]     victim_sel;
    logic                 found_invalid;
    logic                 wb_needed;
    logic                 miss_accept;
    logic                 hit_accept;
    logic [SET_ASSOC-1:0] victim_onehot;

    // Prefer the lowest-index empty way; only fall back to the policy when the set is full.
    always_comb begin
        victim_sel    = repl_index;
        found_invalid = 1'b0;
        for (int i = 0; i < SET_ASSOC; i++) begin
            if (!found_invalid && !line_valid[i]) begin
                victim_sel    = IDX_W'(i);
                found_invalid = 1'b1;
            end
        end
        wb_needed = line_valid[victim_sel] & line_dirty[victim_sel];
    end

    assign hit_accept  = (state_q == IDLE) && lookup_valid && lookup_hit;
    assign miss_accept = (state_q == IDLE) && lookup_valid && !lookup_hit;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q  <= IDLE;
            victim_q <= '0;
            access_q <= '0;
            update_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            access_q <= '0;
            update_q <= 1'b0;
            if (hit_accept) begin
                access_q <= hit_way;
                update_q <= |hit_way;
            end
            if (miss_accept) begin
                victim_q <= victim_sel;
            end
        end
    end

    always_comb begin
        state_d       = state_q;
        victim_onehot = '0;
        victim_onehot[victim_q] = 1'b1;

        case (state_q)
            IDLE: begin
                if (miss_accept) begin
                    state_d = wb_needed ? WB : REFILL;
                end
            end
            WB: begin
                if (wb_ack) begin
                    state_d = REFILL;
                end
            end
            REFILL: begin
                if (rf_ack) begin
                    state_d = COMMIT;
                end
            end
            COMMIT: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        ready      = (state_q == IDLE);
        wb_req     = (state_q == WB);
        rf_req     = (state_q == REFILL);
        alloc_done = (state_q == COMMIT);
        update     = update_q | (state_q == COMMIT);
        access     = access_q | ((state_q == COMMIT) ? victim_onehot : '0);
        victim_way = victim_q;
    end

endmodule

// File: doc/repl_alloc_ctrl.md
# repl_alloc_ctrl

Per-set way-allocation controller for a set-associative cache. It is the consumer side of the replacement-policy interface. It takes tag-compare results, picks a victim way from the set's valid bits or the policy's `repl_index`, and runs the dirty-writeback and refill handshakes. It then drives the `access`/`update` strobes back into the replacement-policy generator. It sits between the cache tag-compare stage and the memory-side writeback/refill engines.

## Interface
Parameters:
- `SET_ASSOC`, default 4: number of ways. Only 2 and 4 are supported.

Ports:
- `clk`  in  1  clock; all state changes on rising edge.
- `rst`  in  1  reset; asynchronous, active-low.
- `lookup_valid`  in  1  tag-compare result valid this cycle.
- `lookup_hit`  in  1  lookup hit; qualified by `lookup_valid`.
- `hit_way`  in  SET_ASSOC  one-hot hit way.
- `line_valid`  in  SET_ASSOC  valid bits of the addressed set.
- `line_dirty`  in  SET_ASSOC  dirty bits of the addressed set.
- `repl_index`  in  $clog2(SET_ASSOC)  victim suggested by the replacement policy.
- `ready`  out  1  controller idle; lookups are accepted.
- `access`  out  SET_ASSOC  one-hot way touched; goes to the policy.
- `update`  out  1  policy state-update strobe.
- `victim_way`  out  $clog2(SET_ASSOC)  latched victim index.
- `wb_req`  out  1  writeback request for `victim_way`.
- `wb_ack`  in  1  writeback complete.
- `rf_req`  out  1  refill request into `victim_way`.
- `rf_ack`  in  1  refill complete.
- `alloc_done`  out  1  one-cycle pulse when allocation commits.

## Operation
- FSM states: IDLE, WB, REFILL, COMMIT.
- IDLE:
  - `ready`=1.
  - Lookups are only sampled here. `lookup_valid` in any other state is ignored.
- Hit in IDLE (`lookup_valid`&`lookup_hit`):
  - Register `hit_way` into `access` and set `update`=1 for the next cycle only.
  - State stays IDLE.
  - `hit_way`=0 produces no pulse (`update` stays 0).
  - Back-to-back hits give back-to-back pulses.
- Miss in IDLE (`lookup_valid`&!`lookup_hit`):
  - Victim selection: the lowest-index way with `line_valid`=0. If all ways are valid, use `repl_index`.
  - Latch the victim into `victim_q`. Also latch `wb_needed` = `line_valid[v]`&`line_dirty[v]`.
  - Next state is WB if `wb_needed`, else REFILL.
- WB:
  - `wb_req`=1, held until `wb_ack` is sampled high at a clock edge; then go to REFILL.
- REFILL:
  - `rf_req`=1, held until `rf_ack` is sampled high; then go to COMMIT.
- COMMIT, one cycle:
  - `access`=onehot(`victim_q`), `update`=1, `alloc_done`=1.
  - Then return to IDLE.
- `victim_way` = `victim_q` at all times. It only changes on a miss accepted in IDLE.
- `wb_ack` outside WB and `rf_ack` outside REFILL are ignored.
- All outputs are decoded from registers; no combinational path from any input to any output.
- `repl_index` is sampled only in the miss cycle. It is not required stable afterwards.

## Timing
- Reset values (while `rst`=0 and immediately on its assertion):
  - State IDLE, `ready`=1.
  - `access`=0, `update`=0, `victim_way`=0, `wb_req`=0, `rf_req`=0, `alloc_done`=0.
- Reset mid-operation aborts any handshake at once. Requests drop asynchronously and no COMMIT pulse is produced.
- Hit: lookup in cycle N gives `access`/`update` in cycle N+1.
- Miss, clean victim:
  - Lookup in cycle N; `ready`=0 and `rf_req`=1 from N+1.
  - `rf_ack` sampled high at the end of cycle M; COMMIT in M+1; IDLE/`ready`=1 in M+2.
  - Minimum miss-to-ready is 3 cycles (ack in N+1).
- Miss, dirty victim:
  - `wb_req` from N+1.
  - `wb_ack` at the end of cycle K; `rf_req` from K+1.
  - Minimum miss-to-ready is 4 cycles.
- Requests deassert in the cycle after the ack edge. Ack may already be high in the first request cycle.
- `wb_req` and `rf_req` are never high together.
- `update` is high for exactly one cycle per hit or commit.

## Test plan
- Reset:
  - Drive `rst`=0 mid-sequence -> `ready`=1; `access`=0, `update`=0, `victim_way`=0, `wb_req`=0, `rf_req`=0, `alloc_done`=0 without waiting for a clock edge.
- Hit:
  - Stimulus (SET_ASSOC=4): `lookup_valid`=1, `lookup_hit`=1, `hit_way`=4'b0100 at cycle N.
  - Response: `access`=4'b0100 and `update`=1 in N+1 only; `ready` stays 1.
  - Same lookup with `hit_way`=0: `update` stays 0.
- Miss, invalid way available:
  - Stimulus: `line_valid`=4'b1011, `repl_index`=0; `rf_ack` 3 cycles after the request.
  - Response: `victim_way`=2; no `wb_req`; `rf_req` for 3 cycles.
  - Then one cycle of `access`=4'b0100, `update`=1, `alloc_done`=1; `ready`=1 the cycle after.
- Miss, dirty victim:
  - Stimulus: `line_valid`=4'b1111, `line_dirty`=4'b1000, `repl_index`=3.
  - Response: `victim_way`=3; `wb_req` held until `wb_ack`; then `rf_req`; then `access`=4'b1000.
  - Variant with `repl_index`=1: no `wb_req`.
- Busy and stray acks:
  - Stimulus: `lookup_valid`=1 pulses during WB/REFILL; `rf_ack`=1 during WB.
  - Response: ignored; state, `victim_way` and requests unchanged.
- Reset during WB:
  - Stimulus: assert `rst`=0 while `wb_req`=1.
  - Response: `wb_req`=0 immediately; no `rf_req` or `alloc_done` after release; next miss is handled normally.
